// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the front end and control path.
//   ILEN            : instruction width in bits
//   NOP_INSTR       : canonical NOP (addi x0, x0, 0)
//   OPC_*           : major opcodes shared with control_unit
//   fetch_state_t   : instruction_fetch FSM states
package riscv_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;

  // Byte step between sequential instructions.
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_HOLD    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter register.
//   clk, rst_n : clock, asynchronous active-low reset (pc <= RESET_PC)
//   load       : load load_pc (takes priority over incr)
//   load_pc    : value to load
//   incr       : advance pc by one instruction (wraps modulo 2^WORDSIZE)
//   pc         : current program counter
module pc_register
  import riscv_pkg::*;
#(
  parameter int unsigned           WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WORDSIZE-1:0] load_pc,
  input  logic                incr,
  output logic [WORDSIZE-1:0] pc
);

  logic [WORDSIZE-1:0] pc_q;
  logic [WORDSIZE-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (incr) begin
      pc_d = pc_q + WORDSIZE'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches instructions over a req/ack
// memory handshake and presents one held instruction to decode via valid/ready.
// A redirect squashes both the in-flight fetch and the held instruction.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem_req     : fetch request (FETCH or DISCARD)
//   imem_addr    : fetch address, stable while imem_req is high
//   imem_ack     : memory completes the request, imem_rdata valid
//   imem_rdata   : fetched instruction word
//   redirect_en  : load redirect_pc (low 2 bits cleared), squash pending work
//   redirect_pc  : redirect target
//   instr_valid  : held instruction valid
//   instr_ready  : consumer accepts the held instruction
//   instruction  : held instruction word
//   instr_pc     : address the held instruction came from
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned         WORDSIZE         = 64,
  parameter int unsigned         INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic                        imem_ack,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
  input  logic                        redirect_en,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         instr_pc
);

  localparam logic [INSTRUCTION_SIZE-1:0] RESET_INSTR = INSTRUCTION_SIZE'(NOP_INSTR);

  fetch_state_t state_q, state_d;

  logic                        valid_q, valid_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic [WORDSIZE-1:0]         ipc_q, ipc_d;
  logic [WORDSIZE-1:0]         stale_q, stale_d;

  logic                        pc_load;
  logic                        pc_incr;
  logic [WORDSIZE-1:0]         pc;
  logic [WORDSIZE-1:0]         redirect_target;

  // Misaligned targets are silently aligned down; no trap is raised here.
  assign redirect_target = redirect_pc & ~WORDSIZE'(3);

  pc_register #(
    .WORDSIZE (WORDSIZE),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .load_pc (redirect_target),
    .incr    (pc_incr),
    .pc      (pc)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    stale_d = stale_q;
    pc_load = 1'b0;
    pc_incr = 1'b0;

    unique case (state_q)
      FS_IDLE: begin
        pc_load = redirect_en;
        state_d = FS_FETCH;
      end

      FS_FETCH: begin
        if (redirect_en) begin
          pc_load = 1'b1;
          if (imem_ack) begin
            state_d = FS_FETCH;
          end else begin
            // Memory still owes an ack for the old address; keep that request
            // open on the old address and throw its data away.
            stale_d = pc;
            state_d = FS_DISCARD;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc;
          valid_d = 1'b1;
          pc_incr = 1'b1;
          state_d = FS_HOLD;
        end
      end

      FS_HOLD: begin
        if (redirect_en) begin
          valid_d = 1'b0;
          pc_load = 1'b1;
          state_d = FS_FETCH;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          state_d = FS_FETCH;
        end
      end

      FS_DISCARD: begin
        // A redirect here only retargets the pc; the stale request must
        // still complete before a new one can be issued.
        pc_load = redirect_en;
        if (imem_ack) begin
          state_d = FS_FETCH;
        end
      end

      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      valid_q <= 1'b0;
      instr_q <= RESET_INSTR;
      ipc_q   <= RESET_PC;
      stale_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      stale_q <= stale_d;
    end
  end

  assign imem_req    = (state_q == FS_FETCH) || (state_q == FS_DISCARD);
  assign imem_addr   = (state_q == FS_DISCARD) ? stale_q : pc;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;

  logic        w_imem_req;
  logic [63:0] w_imem_addr;
  logic        w_instr_valid;
  logic [31:0] w_instruction;
  logic [63:0] w_instr_pc;

  always #5 clk = ~clk;

  instruction_fetch #(
    .WORDSIZE         (64),
    .INSTRUCTION_SIZE (32),
    .RESET_PC         (64'h0)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc)
  );

  // Second instance near the top of the address space: 0-wait memory, always ready.
  instruction_fetch #(
    .WORDSIZE         (64),
    .INSTRUCTION_SIZE (32),
    .RESET_PC         (WRAP_PC)
  ) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ack    (1'b1),
    .imem_rdata  (32'h0),
    .redirect_en (1'b0),
    .redirect_pc (64'h0),
    .instr_valid (w_instr_valid),
    .instr_ready (1'b1),
    .instruction (w_instruction),
    .instr_pc    (w_instr_pc)
  );

  int          checks = 0;
  int          passed = 0;

  // Reference model: consumed instruction addresses form a sequential stream
  // that restarts at the aligned target after every redirect.
  logic [63:0] exp_pc;
  int          delivered;
  int          cyc;
  int          prev_xfer;
  bit          have_prev;
  bit          gap_check;

  // Memory model state.
  bit          busy;
  int          wait_left;
  logic [63:0] req_addr;
  int          fixed_wait;
  int          max_wait;

  logic [63:0] wq[$];

  function automatic logic [31:0] tag(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  // One clock: drive inputs from current outputs, update model, advance to next negedge.
  task automatic tick(input bit rdy, input bit redir, input logic [63:0] tgt);
    if (imem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        req_addr  = imem_addr;
        wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
      end else begin
        chk("imem_addr_stable", imem_addr, req_addr);
      end
      imem_ack   = (wait_left == 0);
      imem_rdata = tag(imem_addr);
    end else begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    instr_ready = rdy;
    redirect_en = redir;
    redirect_pc = tgt;

    if (w_imem_req && wq.size() < 2) wq.push_back(w_imem_addr);

    if (instr_valid && rdy) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instruction", 64'(instruction), 64'(tag(exp_pc)));
      exp_pc    = exp_pc + 64'd4;
      delivered = delivered + 1;
      if (gap_check && have_prev) chk("throughput_gap", 64'(cyc - prev_xfer), 64'd2);
      prev_xfer = cyc;
      have_prev = 1'b1;
    end
    if (redir) exp_pc = {tgt[63:2], 2'b00};

    if (imem_req) begin
      if (imem_ack) busy = 1'b0;
      else wait_left = wait_left - 1;
    end

    @(posedge clk);
    @(negedge clk);
    cyc = cyc + 1;
    redirect_en = 1'b0;
  endtask

  task automatic wait_new_req(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && !busy) begin
        found = 1'b1;
        break;
      end
      tick(1'b1, 1'b0, 64'h0);
    end
    chk(name, 64'(found), 64'd1);
  endtask

  initial begin
    logic [31:0] held_instr;
    logic [63:0] held_pc;
    logic [63:0] old_addr;
    int          d0;
    bit          found;

    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    exp_pc      = 64'h0;
    delivered   = 0;
    cyc         = 0;
    prev_xfer   = 0;
    have_prev   = 1'b0;
    gap_check   = 1'b0;
    busy        = 1'b0;
    wait_left   = 0;
    req_addr    = '0;
    fixed_wait  = 0;
    max_wait    = 0;

    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'h13);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_instr_pc", instr_pc, 64'h0);

    rst_n = 1'b1;
    chk("idle_no_req", 64'(imem_req), 64'd0);
    tick(1'b1, 1'b0, 64'h0);
    chk("req_after_release", 64'(imem_req), 64'd1);

    // 0-wait stream, consumer always ready: one instruction every 2 cycles
    gap_check = 1'b1;
    d0 = delivered;
    repeat (10) tick(1'b1, 1'b0, 64'h0);
    gap_check = 1'b0;
    chk("stream_count", 64'(delivered - d0), 64'd5);

    // Backpressure in HOLD
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 64'h0);
    end
    chk("hold_reached", 64'(found), 64'd1);
    held_instr = instruction;
    held_pc    = instr_pc;
    repeat (5) begin
      tick(1'b0, 1'b0, 64'h0);
      chk("bp_valid", 64'(instr_valid), 64'd1);
      chk("bp_instruction", 64'(instruction), 64'(held_instr));
      chk("bp_instr_pc", instr_pc, held_pc);
      chk("bp_no_req", 64'(imem_req), 64'd0);
    end
    repeat (4) tick(1'b1, 1'b0, 64'h0);

    // Redirect during a 3-wait fetch: stale address kept until ack
    fixed_wait = 3;
    wait_new_req("t4_req_seen");
    old_addr = imem_addr;
    tick(1'b1, 1'b1, 64'h200);
    chk("discard_req", 64'(imem_req), 64'd1);
    chk("discard_addr", imem_addr, old_addr);
    d0 = delivered;
    repeat (12) tick(1'b1, 1'b0, 64'h0);
    chk("t4_progress", 64'(delivered > d0), 64'd1);

    // Misaligned redirect target
    wait_new_req("t4b_req_seen");
    tick(1'b1, 1'b1, 64'h203);
    d0 = delivered;
    repeat (12) tick(1'b1, 1'b0, 64'h0);
    chk("t4b_progress", 64'(delivered > d0), 64'd1);

    // Redirect coincident with 0-wait ack
    fixed_wait = 0;
    wait_new_req("t5_req_seen");
    tick(1'b1, 1'b1, 64'h300);
    d0 = delivered;
    repeat (6) tick(1'b1, 1'b0, 64'h0);
    chk("t5_progress", 64'(delivered > d0), 64'd1);

    // Redirect coincident with valid&ready in HOLD
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 64'h0);
    end
    chk("t5b_hold_reached", 64'(found), 64'd1);
    d0 = delivered;
    tick(1'b1, 1'b1, 64'h400);
    chk("t5b_consumed_once", 64'(delivered - d0), 64'd1);
    chk("t5b_valid_dropped", 64'(instr_valid), 64'd0);
    repeat (6) tick(1'b1, 1'b0, 64'h0);

    // Randomized traffic
    fixed_wait = -1;
    max_wait   = 3;
    d0 = delivered;
    for (int i = 0; i < 300; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, t);
    end
    chk("random_progress", 64'(delivered - d0 >= 20), 64'd1);

    // Reset asserted mid-request
    fixed_wait = 3;
    wait_new_req("t1_req_seen");
    #2 rst_n = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("midrst_imem_req", 64'(imem_req), 64'd0);
    chk("midrst_valid", 64'(instr_valid), 64'd0);
    chk("midrst_instruction", 64'(instruction), 64'h13);
    chk("midrst_imem_addr", imem_addr, 64'h0);
    @(negedge clk);
    @(negedge clk);
    busy      = 1'b0;
    exp_pc    = 64'h0;
    have_prev = 1'b0;
    rst_n     = 1'b1;
    chk("midrst_idle", 64'(imem_req), 64'd0);
    tick(1'b1, 1'b0, 64'h0);
    chk("midrst_req_after_release", 64'(imem_req), 64'd1);
    d0 = delivered;
    repeat (10) tick(1'b1, 1'b0, 64'h0);
    chk("midrst_progress", 64'(delivered > d0), 64'd1);

    // PC wrap
    chk("wrap_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("wrap_first_addr", wq[0], WRAP_PC);
      chk("wrap_second_addr", wq[1], 64'h0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
